// File: rtl/ram_bus_pkg.sv
// Shared definitions for the ram_bus memory: FSM state encodings,
// response codes and the big-endian byte-lane mapping.
package ram_bus_pkg;

  localparam int LANES = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  // Lane 0 is the byte at addr+0, which lives in bits [63:56] of the data word.
  function automatic int lane_lsb(input int lane);
    return 56 - 8 * lane;
  endfunction

endpackage

// File: rtl/ram_bus_if.sv
// Request/response handshake bundle between a bus master and ram_bus.
interface ram_bus_if
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_byte_array.sv
// Byte-wide storage with an 8-lane write port (one enable per lane) and an
// 8-lane registered read port. Lane i addresses byte base+i. Storage is never
// reset; only the read register is.
module ram_byte_array
  import ram_bus_pkg::*;
#(
  parameter int    NUM_BYTES = 4096,
  parameter string INIT_FILE = "",
  parameter int    IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] base,
  input  logic [LANES-1:0] wr_lane,
  input  logic [63:0]      wdata,
  input  logic             rd_en,
  input  logic             rd_clr,
  output logic [63:0]      rdata
);

  logic [7:0]       mem [NUM_BYTES];
  logic [IDX_W-1:0] lane_idx [LANES];

  // Per-lane byte index; callers only enable lanes that fall inside the array.
  always_comb begin
    for (int i = 0; i < LANES; i++) lane_idx[i] = base + IDX_W'(i);
  end

  // Commit strobed lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane[i]) mem[lane_idx[i]] <= wdata[lane_lsb(i) +: 8];
    end
  end

  // Capture all 8 lanes on a read, zero on write/error, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      for (int i = 0; i < LANES; i++) rdata[lane_lsb(i) +: 8] <= mem[lane_idx[i]];
    end
  end

endmodule

// File: rtl/ram_bus.sv
// Byte-addressed test memory with request/response handshake, per-byte
// strobes, programmable wait states and out-of-range error reporting.
// The access itself happens on the accepting edge; the FSM only paces the
// response.
module ram_bus
  import ram_bus_pkg::*;
#(
  parameter int    NUM_BYTES   = 4096,
  parameter int    ADDR_W      = 64,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic       clk,
  input logic       rst_n,
  ram_bus_if.slave  bus
);

  localparam int              IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [ADDR_W:0] LIMIT     = (ADDR_W + 1)'(NUM_BYTES);
  localparam logic [7:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [7:0]       wait_cnt;
  logic             rsp_err_q;
  logic             accept;
  logic             range_err;
  logic [ADDR_W:0]  last_byte;
  logic [LANES-1:0] wr_lane;

  assign bus.req_ready = (state == ST_IDLE) & rst_n;
  assign accept        = bus.req_valid & bus.req_ready;

  // One extra bit so addresses near the top of the space cannot wrap into range.
  assign last_byte = {1'b0, bus.req_addr} + (ADDR_W + 1)'(7);
  assign range_err = (last_byte >= LIMIT);

  // Lane i is strobed by be[7-i]; an erroring access writes nothing at all.
  always_comb begin
    wr_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_lane[i] = accept & bus.req_we & ~range_err & bus.req_be[LANES-1-i];
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt == 8'd0) state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Wait-state timer: loaded on accept, counts down, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wait_cnt <= 8'd0;
    else if (accept)                             wait_cnt <= WAIT_LOAD;
    else if (state == ST_WAIT && wait_cnt != 0)  wait_cnt <= wait_cnt - 8'd1;
  end

  // Response code, frozen from accept until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err_q <= RSP_OK;
    else if (accept) rsp_err_q <= range_err ? RSP_ERR : RSP_OK;
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_err   = rsp_err_q;

  ram_byte_array #(
    .NUM_BYTES (NUM_BYTES),
    .INIT_FILE (INIT_FILE),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .base    (bus.req_addr[IDX_W-1:0]),
    .wr_lane (wr_lane),
    .wdata   (bus.req_wdata),
    .rd_en   (accept & ~bus.req_we & ~range_err),
    .rd_clr  (accept & (bus.req_we | range_err)),
    .rdata   (bus.rsp_rdata)
  );

endmodule

// File: tb/tb_ram_bus.sv
// Bench for ram_bus: one instance with no wait states, one with three.
// Both are checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_ram_bus;

  localparam int NB  = 4096;
  localparam int AW  = 64;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  drv_valid, drv_we, drv_rsp_ready;
  logic [63:0] drv_addr  [2];
  logic [63:0] drv_wdata [2];
  logic [7:0]  drv_be    [2];
  logic [1:0]  obs_req_ready, obs_rsp_valid, obs_rsp_err;
  logic [63:0] obs_rdata [2];

  ram_bus_if #(.ADDR_W(AW)) bus0 ();
  ram_bus_if #(.ADDR_W(AW)) bus1 ();

  assign bus0.req_valid = drv_valid[0];
  assign bus0.req_we    = drv_we[0];
  assign bus0.req_addr  = drv_addr[0];
  assign bus0.req_wdata = drv_wdata[0];
  assign bus0.req_be    = drv_be[0];
  assign bus0.rsp_ready = drv_rsp_ready[0];
  assign bus1.req_valid = drv_valid[1];
  assign bus1.req_we    = drv_we[1];
  assign bus1.req_addr  = drv_addr[1];
  assign bus1.req_wdata = drv_wdata[1];
  assign bus1.req_be    = drv_be[1];
  assign bus1.rsp_ready = drv_rsp_ready[1];

  assign obs_req_ready = {bus1.req_ready, bus0.req_ready};
  assign obs_rsp_valid = {bus1.rsp_valid, bus0.rsp_valid};
  assign obs_rsp_err   = {bus1.rsp_err,   bus0.rsp_err};
  assign obs_rdata[0]  = bus0.rsp_rdata;
  assign obs_rdata[1]  = bus1.rsp_rdata;

  ram_bus #(.NUM_BYTES(NB), .ADDR_W(AW), .WAIT_STATES(WS0), .INIT_FILE("")) dut0 (
    .clk (clk), .rst_n (rst_n[0]), .bus (bus0.slave));
  ram_bus #(.NUM_BYTES(NB), .ADDR_W(AW), .WAIT_STATES(WS1), .INIT_FILE("")) dut1 (
    .clk (clk), .rst_n (rst_n[1]), .bus (bus1.slave));

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [2][NB];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int ws(input int sel);
    return (sel == 0) ? WS0 : WS1;
  endfunction

  function automatic bit mdl_err(input logic [63:0] addr);
    return ({1'b0, addr} + 65'd7) >= 65'(NB);
  endfunction

  function automatic logic [63:0] mdl_read(input int sel, input logic [63:0] addr);
    logic [63:0] r = '0;
    if (mdl_err(addr)) return '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], mdl[sel][int'(addr) + i]};
    return r;
  endfunction

  function automatic void mdl_write(input int sel, input logic [63:0] addr,
                                    input logic [63:0] wdata, input logic [7:0] be);
    if (mdl_err(addr)) return;
    for (int i = 0; i < 8; i++)
      if (be[7-i]) mdl[sel][int'(addr) + i] = wdata[63 - 8*i -: 8];
  endfunction

  // One full transaction: request, wait for response, hold it for `hold`
  // cycles with rsp_ready low, then complete the handshake.
  task automatic txn(input int sel, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] be, input int hold,
                     output logic [63:0] got);
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          n;
    bit          ready_seen;
    got     = '0;
    exp_err = mdl_err(addr);
    exp_rdata = we ? 64'd0 : mdl_read(sel, addr);
    @(negedge clk);
    drv_valid[sel] = 1'b1; drv_we[sel] = we; drv_addr[sel] = addr;
    drv_wdata[sel] = wdata; drv_be[sel] = be; drv_rsp_ready[sel] = 1'b0;
    n = 0;
    while (!obs_req_ready[sel] && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 64'(n), 64'd0);
    if (n >= 50) begin drv_valid[sel] = 1'b0; return; end
    @(posedge clk);
    if (we) mdl_write(sel, addr, wdata, be);
    #1;
    // Keep offering a stray in-range write while busy; it must be ignored.
    drv_we[sel] = 1'b1; drv_be[sel] = 8'hFF;
    drv_addr[sel] = 64'($urandom_range(0, NB - 8));
    drv_wdata[sel] = {$urandom, $urandom};
    n = 0; ready_seen = 0;
    do begin
      @(negedge clk); n++;
      if (obs_req_ready[sel]) ready_seen = 1;
    end while (!obs_rsp_valid[sel] && n < 300);
    chk("latency", 64'(n), 64'(1 + ws(sel)));
    chk("busy_ready", 64'(ready_seen), 64'd0);
    if (!obs_rsp_valid[sel]) begin drv_valid[sel] = 1'b0; return; end
    got = obs_rdata[sel];
    chk("rdata", obs_rdata[sel], exp_rdata);
    chk("err", 64'(obs_rsp_err[sel]), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(obs_rsp_valid[sel]), 64'd1);
      chk("hold_rdata", obs_rdata[sel], exp_rdata);
      chk("hold_err", 64'(obs_rsp_err[sel]), 64'(exp_err));
      chk("hold_ready", 64'(obs_req_ready[sel]), 64'd0);
    end
    drv_valid[sel] = 1'b0;
    drv_rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    drv_rsp_ready[sel] = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 64'(obs_rsp_valid[sel]), 64'd0);
    chk("idle_ready", 64'(obs_req_ready[sel]), 64'd1);
  endtask

  task automatic init_mem(input int sel);
    logic [63:0] g;
    for (int a = 0; a < NB / 8; a++) txn(sel, 1'b1, 64'(a * 8), {$urandom, $urandom}, 8'hFF, 0, g);
    txn(sel, 1'b1, 64'd0, 64'h0001020304050607, 8'hFF, 0, g);
    txn(sel, 1'b1, 64'd8, 64'h08090A0B0C0D0E0F, 8'hFF, 0, g);
  endtask

  task automatic rand_ops(input int sel, input int count);
    logic [63:0] g, addr;
    for (int k = 0; k < count; k++) begin
      case ($urandom_range(0, 9))
        0:       addr = {$urandom, $urandom};
        1:       addr = 64'($urandom_range(NB - 12, NB - 1));
        default: addr = 64'($urandom_range(0, NB - 1));
      endcase
      txn(sel, 1'($urandom), addr, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), g);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic [63:0] a5;
    logic [19:0] rdy_pat, vld_pat;
    int          acc;

    rst_n = 2'b00;
    drv_valid = '0; drv_we = '0; drv_rsp_ready = '0;
    for (int s = 0; s < 2; s++) begin drv_addr[s] = '0; drv_wdata[s] = '0; drv_be[s] = '0; end
    #3;
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 64'(obs_req_ready[s]), 64'd0);
      chk("rst_rsp_valid", 64'(obs_rsp_valid[s]), 64'd0);
      chk("rst_rdata", obs_rdata[s], 64'd0);
      chk("rst_err", 64'(obs_rsp_err[s]), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 2'b11;

    fork
      init_mem(0);
      init_mem(1);
    join

    // Pattern bytes 00..0F at the bottom of memory
    txn(0, 1'b0, 64'h3, '0, 8'h00, 0, got);
    chk("t1_const", got, 64'h030405060708090A);

    // Partial strobe: lanes 0,2,5,7 new, lanes 1,3,4,6 keep 06,08,09,0B
    txn(0, 1'b1, 64'h5, 64'h1122334455667788, 8'b1010_0101, 0, got);
    txn(0, 1'b0, 64'h5, '0, 8'h00, 0, got);
    chk("t2_const", got, 64'h1106330809660B88);

    // Range boundaries
    txn(0, 1'b0, 64'hFF9, '0, 8'h00, 0, got);
    chk("t3_err_rdata", got, 64'd0);
    txn(0, 1'b1, 64'hFF9, {$urandom, $urandom}, 8'hFF, 0, got);
    txn(0, 1'b0, 64'hFF8, '0, 8'h00, 0, got);
    txn(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 8'h00, 0, got);
    txn(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, {$urandom, $urandom}, 8'hFF, 1, got);
    a5 = 64'($urandom_range(0, NB - 8));
    txn(0, 1'b1, a5, {$urandom, $urandom}, 8'h00, 0, got);
    txn(0, 1'b0, a5, '0, 8'h00, 0, got);

    // Wait states with a stalled consumer
    txn(1, 1'b0, 64'h3, '0, 8'h00, 5, got);
    chk("t4_const", got, 64'h030405060708090A);
    txn(1, 1'b0, 64'hFF9, '0, 8'h00, 2, got);

    // Reset during the wait phase of a write
    a5 = 64'($urandom_range(0, NB - 8));
    @(negedge clk);
    drv_valid[1] = 1'b1; drv_we[1] = 1'b1; drv_addr[1] = a5;
    drv_wdata[1] = {$urandom, $urandom}; drv_be[1] = 8'hFF;
    chk("t5_ready", 64'(obs_req_ready[1]), 64'd1);
    @(posedge clk);
    mdl_write(1, a5, drv_wdata[1], 8'hFF);
    #1 drv_valid[1] = 1'b0;
    @(negedge clk);
    #1 rst_n[1] = 1'b0;
    #1;
    chk("t5_rst_ready", 64'(obs_req_ready[1]), 64'd0);
    chk("t5_rst_valid", 64'(obs_rsp_valid[1]), 64'd0);
    chk("t5_rst_rdata", obs_rdata[1], 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_no_rsp", 64'(obs_rsp_valid[1]), 64'd0);
    end
    rst_n[1] = 1'b1;
    txn(1, 1'b0, a5, '0, 8'h00, 0, got);

    // Back-to-back reads: one accept every two cycles
    a5 = 64'($urandom_range(0, NB - 8));
    @(negedge clk);
    drv_valid[0] = 1'b1; drv_we[0] = 1'b0; drv_addr[0] = a5; drv_rsp_ready[0] = 1'b1;
    acc = 0; rdy_pat = '0; vld_pat = '0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      rdy_pat[c] = obs_req_ready[0];
      vld_pat[c] = obs_rsp_valid[0];
      if (obs_req_ready[0]) acc++;
      if (obs_rsp_valid[0]) chk("t6_rdata", obs_rdata[0], mdl_read(0, a5));
    end
    drv_valid[0] = 1'b0;
    @(negedge clk);
    drv_rsp_ready[0] = 1'b0;
    chk("t6_accepts", 64'(acc), 64'd10);
    chk("t6_ready_pat", 64'(rdy_pat), 64'h55555);
    chk("t6_valid_pat", 64'(vld_pat), 64'hAAAAA);

    fork
      rand_ops(0, 80);
      rand_ops(1, 60);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
